// File: rtl/pipe_controller.sv
// Control and hazard unit for the 5-stage MIPS-subset datapath: D-stage decode,
// E/M/W control pipeline, load-use stall, branch/jump flush and forwarding selects.
module pipe_controller #(
   parameter int unsigned RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [5:0]    Opcode,
   input  logic [5:0]    Funct,
   input  logic [RW-1:0] RsD,
   input  logic [RW-1:0] RtD,
   input  logic          ZeroM,
   input  logic [RW-1:0] WriteRegM,
   input  logic [RW-1:0] WriteRegW,
   output logic          RegDstE,
   output logic          ALUSrcE,
   output logic [2:0]    ALUControlE,
   output logic          MemWriteM,
   output logic          MemToRegW,
   output logic          RegWriteW,
   output logic          PCSrcM,
   output logic          JumpD,
   output logic          StallF,
   output logic          StallD,
   output logic          FlushD,
   output logic [1:0]    ForwardAE,
   output logic [1:0]    ForwardBE
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   logic          reg_write_d, reg_dst_d, alu_src_d, branch_d, mem_write_d, mem_to_reg_d, jump_d;
   logic [2:0]    alu_ctrl_d;
   logic          reg_write_e, reg_dst_e, alu_src_e, branch_e, mem_write_e, mem_to_reg_e;
   logic [2:0]    alu_ctrl_e;
   logic [RW-1:0] rs_e, rt_e;
   logic          reg_write_m, branch_m, mem_write_m, mem_to_reg_m;
   logic          reg_write_w, mem_to_reg_w;
   logic          lwstall;

   always_comb begin
      reg_write_d  = 1'b0;
      reg_dst_d    = 1'b0;
      alu_src_d    = 1'b0;
      branch_d     = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      jump_d       = 1'b0;
      alu_ctrl_d   = 3'b000;
      case (Opcode)
         OP_RTYPE: begin
            reg_write_d = 1'b1;
            reg_dst_d   = 1'b1;
            case (Funct)
               FN_ADD:  alu_ctrl_d = 3'b010;
               FN_SUB:  alu_ctrl_d = 3'b110;
               FN_AND:  alu_ctrl_d = 3'b000;
               FN_OR:   alu_ctrl_d = 3'b001;
               FN_SLT:  alu_ctrl_d = 3'b111;
               default: begin
                  reg_write_d = 1'b0;
                  reg_dst_d   = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 1'b1;
            mem_to_reg_d = 1'b1;
            alu_ctrl_d   = 3'b010;
         end
         OP_SW: begin
            mem_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_ctrl_d  = 3'b010;
         end
         OP_BEQ: begin
            branch_d   = 1'b1;
            alu_ctrl_d = 3'b110;
         end
         OP_ADDI: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_ctrl_d  = 3'b010;
         end
         OP_J:    jump_d = 1'b1;
         default: ;
      endcase
   end

   assign PCSrcM  = branch_m & ZeroM;
   assign lwstall = mem_to_reg_e & reg_write_e & (rt_e != '0) & ((rt_e == RsD) | (rt_e == RtD));

   // Decode is combinational, so qualify the jump with reset to keep every output quiet in reset.
   assign JumpD  = jump_d & reset;
   assign StallF = lwstall & ~PCSrcM;
   assign StallD = lwstall & ~PCSrcM;
   assign FlushD = PCSrcM | (JumpD & ~lwstall);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || lwstall || PCSrcM) begin
         reg_write_e  <= 1'b0;
         reg_dst_e    <= 1'b0;
         alu_src_e    <= 1'b0;
         branch_e     <= 1'b0;
         mem_write_e  <= 1'b0;
         mem_to_reg_e <= 1'b0;
         alu_ctrl_e   <= '0;
         rs_e         <= '0;
         rt_e         <= '0;
      end else begin
         reg_write_e  <= reg_write_d;
         reg_dst_e    <= reg_dst_d;
         alu_src_e    <= alu_src_d;
         branch_e     <= branch_d;
         mem_write_e  <= mem_write_d;
         mem_to_reg_e <= mem_to_reg_d;
         alu_ctrl_e   <= alu_ctrl_d;
         rs_e         <= RsD;
         rt_e         <= RtD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || PCSrcM) begin
         reg_write_m  <= 1'b0;
         branch_m     <= 1'b0;
         mem_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
      end else begin
         reg_write_m  <= reg_write_e;
         branch_m     <= branch_e;
         mem_write_m  <= mem_write_e;
         mem_to_reg_m <= mem_to_reg_e;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
      end else begin
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
      end
   end

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (reg_write_m && (WriteRegM != '0) && (WriteRegM == rs_e))
         ForwardAE = 2'b10;
      else if (reg_write_w && (WriteRegW != '0) && (WriteRegW == rs_e))
         ForwardAE = 2'b01;
      if (reg_write_m && (WriteRegM != '0) && (WriteRegM == rt_e))
         ForwardBE = 2'b10;
      else if (reg_write_w && (WriteRegW != '0) && (WriteRegW == rt_e))
         ForwardBE = 2'b01;
   end

   assign RegDstE     = reg_dst_e;
   assign ALUSrcE     = alu_src_e;
   assign ALUControlE = alu_ctrl_e;
   assign MemWriteM   = mem_write_m;
   assign MemToRegW   = mem_to_reg_w;
   assign RegWriteW   = reg_write_w;
endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: E-stage expectations queued at issue time,
// carried through bench-side M/W slots, hazard/forward selects checked per step.
module tb_pipe_controller;
   localparam int unsigned RW = 5;
   localparam logic [5:0] R    = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] J    = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;
   localparam logic [5:0] FADD = 6'b100000;
   localparam logic [5:0] FSUB = 6'b100010;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic [2:0] alu;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       branch;
   } ctl_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    Opcode, Funct;
   logic [RW-1:0] RsD, RtD, WriteRegM, WriteRegW;
   logic          ZeroM;
   logic          RegDstE, ALUSrcE, MemWriteM, MemToRegW, RegWriteW, PCSrcM, JumpD;
   logic          StallF, StallD, FlushD;
   logic [2:0]    ALUControlE;
   logic [1:0]    ForwardAE, ForwardBE;

   int   vectors = 0;
   int   miscompares = 0;
   ctl_t qe[$];
   ctl_t e_now, m_now, w_now;
   logic exp_pcsrc;

   logic [5:0] sweep_op [11] = '{R, R, R, R, R, LW, SW, BEQ, ADDI, J, BAD};
   logic [5:0] sweep_fn [11] = '{FADD, FSUB, 6'b100100, 6'b100101, 6'b101010, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

   always #5 clk = ~clk;

   pipe_controller #(.RW(RW)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .RsD(RsD), .RtD(RtD),
      .ZeroM(ZeroM), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM),
      .MemToRegW(MemToRegW), .RegWriteW(RegWriteW), .PCSrcM(PCSrcM), .JumpD(JumpD),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
   );

   function automatic ctl_t dec(input logic [5:0] op, input logic [5:0] fn);
      ctl_t c;
      c = '0;
      case (op)
         R: begin
            c.regdst = 1'b1;
            c.regwrite = 1'b1;
            case (fn)
               6'b100000: c.alu = 3'b010;
               6'b100010: c.alu = 3'b110;
               6'b100100: c.alu = 3'b000;
               6'b100101: c.alu = 3'b001;
               6'b101010: c.alu = 3'b111;
               default:   c = '0;
            endcase
         end
         LW:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.memtoreg = 1'b1; c.alu = 3'b010; end
         SW:   begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.alu = 3'b010; end
         BEQ:  begin c.branch = 1'b1; c.alu = 3'b110; end
         ADDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alu = 3'b010; end
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wrm, input logic [4:0] wrw,
                        input logic zero, input logic bub);
      ctl_t c;
      Opcode = op; Funct = fn; RsD = rs; RtD = rt;
      WriteRegM = wrm; WriteRegW = wrw; ZeroM = zero;
      if (bub) c = '0;
      else     c = dec(op, fn);
      qe.push_back(c);
      exp_pcsrc = m_now.branch & zero;
      #1;
      check("PCSrcM", PCSrcM, exp_pcsrc);
      check("JumpD", JumpD, op == J);
   endtask

   task automatic haz(input string tag, input logic stall, input logic flush,
                      input logic [1:0] fa, input logic [1:0] fb);
      check({tag, ".StallF"}, StallF, stall);
      check({tag, ".StallD"}, StallD, stall);
      check({tag, ".FlushD"}, FlushD, flush);
      check({tag, ".ForwardAE"}, ForwardAE, fa);
      check({tag, ".ForwardBE"}, ForwardBE, fb);
   endtask

   task automatic tick();
      ctl_t e;
      @(posedge clk);
      #1;
      w_now = m_now;
      if (exp_pcsrc) m_now = '0;
      else           m_now = e_now;
      vectors++;
      assert (qe.size() != 0) else begin
         miscompares++;
         $error("FAIL sb_empty: observed 0 entries expected >0");
      end
      if (qe.size() != 0) e = qe.pop_front();
      else                e = '0;
      e_now = e;
      check("RegDstE", RegDstE, e.regdst);
      check("ALUSrcE", ALUSrcE, e.alusrc);
      check("ALUControlE", ALUControlE, e.alu);
      check("MemWriteM", MemWriteM, m_now.memwrite);
      check("MemToRegW", MemToRegW, w_now.memtoreg);
      check("RegWriteW", RegWriteW, w_now.regwrite);
   endtask

   task automatic quiet(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt);
      issue(op, fn, rs, rt, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("quiet", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();
   endtask

   task automatic clear_model();
      qe.delete();
      e_now = '0; m_now = '0; w_now = '0;
      exp_pcsrc = 1'b0;
   endtask

   function automatic logic [31:0] all_outs();
      return {15'd0, RegDstE, ALUSrcE, ALUControlE, MemWriteM, MemToRegW, RegWriteW, PCSrcM,
              JumpD, StallF, StallD, FlushD, ForwardAE, ForwardBE};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_model();
      reset = 1'b0;
      Opcode = J; Funct = FADD; RsD = 5'd3; RtD = 5'd3;
      ZeroM = 1'b1; WriteRegM = 5'd3; WriteRegW = 5'd3;
      repeat (2) @(posedge clk);
      #2;
      check("rst.outs_j", all_outs(), 32'd0);
      Opcode = 6'($urandom); Funct = 6'($urandom);
      RsD = 5'($urandom); RtD = 5'($urandom);
      #2;
      check("rst.outs_rand", all_outs(), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // decode sweep, first entry is add right after reset release
      for (int i = 0; i < 11; i++) begin
         issue(sweep_op[i], sweep_fn[i], 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         haz("dec", 1'b0, sweep_op[i] == J, 2'b00, 2'b00);
         tick();
      end
      repeat (3) quiet(BAD, 6'd0, 5'd0, 5'd0);

      // forward from M
      quiet(R, FADD, 5'd1, 5'd2);
      quiet(R, FSUB, 5'd3, 5'd3);
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      haz("fwd_m", 1'b0, 1'b0, 2'b10, 2'b10);
      tick();

      // forward from W with a non-writing nop in M carrying a matching register
      quiet(R, FADD, 5'd1, 5'd2);
      quiet(BAD, 6'd0, 5'd0, 5'd0);
      quiet(R, FSUB, 5'd3, 5'd5);
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0);
      haz("fwd_w", 1'b0, 1'b0, 2'b01, 2'b00);
      tick();

      // writes to $0 are never forwarded
      quiet(R, FADD, 5'd1, 5'd2);
      quiet(R, FSUB, 5'd0, 5'd0);
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("fwd_r0_m", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("fwd_r0_w", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();

      // $3 live in both M and W: M wins
      quiet(R, FADD, 5'd1, 5'd2);
      quiet(R, FADD, 5'd1, 5'd2);
      quiet(R, FSUB, 5'd3, 5'd3);
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0);
      haz("fwd_mw", 1'b0, 1'b0, 2'b10, 2'b10);
      tick();

      // load-use: one stall cycle, bubble into E, then W forwarding
      quiet(LW, 6'd0, 5'd1, 5'd2);
      issue(R, FADD, 5'd2, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
      haz("lu_stall", 1'b1, 1'b0, 2'b00, 2'b00);
      tick();
      issue(R, FADD, 5'd2, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("lu_release", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
      haz("lu_fwd", 1'b0, 1'b0, 2'b01, 2'b00);
      tick();
      quiet(LW, 6'd0, 5'd1, 5'd0);
      issue(R, FADD, 5'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("lu_r0", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();

      // taken branch squashes the sw behind it and the instruction in D
      quiet(BEQ, 6'd0, 5'd1, 5'd2);
      quiet(SW, 6'd0, 5'd0, 5'd0);
      issue(R, FADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      haz("br_taken", 1'b0, 1'b1, 2'b00, 2'b00);
      tick();
      quiet(BAD, 6'd0, 5'd0, 5'd0);
      quiet(BAD, 6'd0, 5'd0, 5'd0);

      // untaken branch: sw proceeds
      quiet(BEQ, 6'd0, 5'd1, 5'd2);
      quiet(SW, 6'd0, 5'd0, 5'd0);
      issue(R, FADD, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("br_not", 1'b0, 1'b0, 2'b00, 2'b00);
      tick();
      quiet(BAD, 6'd0, 5'd0, 5'd0);

      // load-use coinciding with redirect
      quiet(BEQ, 6'd0, 5'd0, 5'd0);
      quiet(LW, 6'd0, 5'd0, 5'd2);
      issue(R, FADD, 5'd2, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
      haz("coll_br", 1'b0, 1'b1, 2'b00, 2'b00);
      tick();
      quiet(BAD, 6'd0, 5'd0, 5'd0);
      quiet(BAD, 6'd0, 5'd0, 5'd0);

      // jump behind a load-use stall is held, then flushes
      quiet(LW, 6'd0, 5'd0, 5'd2);
      issue(J, 6'd0, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      haz("coll_j", 1'b1, 1'b0, 2'b00, 2'b00);
      tick();
      issue(J, 6'd0, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      haz("j_flush", 1'b0, 1'b1, 2'b00, 2'b00);
      tick();
      quiet(BAD, 6'd0, 5'd0, 5'd0);

      // reset in the middle of a taken branch
      quiet(BEQ, 6'd0, 5'd0, 5'd0);
      quiet(R, FADD, 5'd0, 5'd0);
      issue(BAD, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      haz("rst_br_pre", 1'b0, 1'b1, 2'b00, 2'b00);
      reset = 1'b0;
      #1;
      check("rst_mid.PCSrcM", PCSrcM, 1'b0);
      check("rst_mid.outs", all_outs(), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      clear_model();
      for (int i = 0; i < 3; i++) begin
         issue(BAD, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
         haz("post_rst", 1'b0, 1'b0, 2'b00, 2'b00);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
